// File: rtl/conv1_ctrl_seq.sv
// rtl/conv1_ctrl_seq.sv - layer-1 convolution sequencer: weight load, row window fill, column MAC issue
module conv1_ctrl_seq #(
  parameter int NUM_FILT      = 6,
  parameter int NUM_FILT_ROWS = 5,
  parameter int IMG_ROWS      = 32,
  parameter int NUM_OUT_ROWS  = 28,
  parameter int NUM_COL_WIN   = 7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       wght_reload_i,
  input  logic       mac_rdy_i,
  output logic       wght_rd_en_o,
  output logic [4:0] wght_rd_addr_o,
  output logic       row_rd_en_o,
  output logic [4:0] row_rd_addr_o,
  output logic [2:0] col_sel_o,
  output logic       mac_vld_o,
  output logic [4:0] out_row_o,
  output logic       busy_o,
  output logic       frame_done_o
);

  localparam logic [4:0] WGHT_LAST  = 5'(NUM_FILT * NUM_FILT_ROWS - 1);
  localparam logic [2:0] PRIME_LAST = 3'(NUM_FILT_ROWS - 1);
  localparam logic [4:0] ROW_AHEAD  = 5'(NUM_FILT_ROWS - 1);
  localparam logic [4:0] IMG_LAST   = 5'(IMG_ROWS - 1);
  localparam logic [4:0] OUT_LAST   = 5'(NUM_OUT_ROWS - 1);
  localparam logic [2:0] COL_LAST   = 3'(NUM_COL_WIN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_WGHT,
    S_LD_ROWS,
    S_SETTLE,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] wght_cnt;
  logic [2:0] prime_cnt;
  logic [2:0] col_cnt;
  logic [4:0] out_row;
  logic [5:0] row_sum;

  // Output row r needs image row r+4 shifted in; clamp so the address never leaves the image.
  assign row_sum = {1'b0, out_row} + {1'b0, ROW_AHEAD};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      wght_cnt  <= '0;
      prime_cnt <= '0;
      col_cnt   <= '0;
      out_row   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            wght_cnt  <= '0;
            prime_cnt <= '0;
            col_cnt   <= '0;
            out_row   <= '0;
          end
        end
        S_LD_WGHT: begin
          if (wght_cnt != WGHT_LAST) wght_cnt <= wght_cnt + 5'd1;
        end
        S_LD_ROWS: begin
          if (out_row == '0 && prime_cnt != PRIME_LAST) prime_cnt <= prime_cnt + 3'd1;
        end
        S_SETTLE: begin
          col_cnt <= '0;
        end
        S_COMPUTE: begin
          // The last window of the last row leaves both counters at their terminal values.
          if (mac_rdy_i) begin
            if (col_cnt != COL_LAST) begin
              col_cnt <= col_cnt + 3'd1;
            end else if (out_row != OUT_LAST) begin
              out_row <= out_row + 5'd1;
              col_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt      = state;
    wght_rd_en_o   = 1'b0;
    wght_rd_addr_o = '0;
    row_rd_en_o    = 1'b0;
    row_rd_addr_o  = '0;
    col_sel_o      = '0;
    mac_vld_o      = 1'b0;
    out_row_o      = '0;
    busy_o         = 1'b0;
    frame_done_o   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_i) state_nxt = wght_reload_i ? S_LD_WGHT : S_LD_ROWS;
      end
      S_LD_WGHT: begin
        if (wght_cnt == WGHT_LAST) state_nxt = S_LD_ROWS;
      end
      S_LD_ROWS: begin
        if (out_row != '0 || prime_cnt == PRIME_LAST) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (mac_rdy_i && col_cnt == COL_LAST)
          state_nxt = (out_row == OUT_LAST) ? S_DONE : S_LD_ROWS;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Outputs are forced low for the whole reset cycle, not just after the edge.
    if (!rst_i) begin
      out_row_o = out_row;
      busy_o    = (state != S_IDLE);
      case (state)
        S_LD_WGHT: begin
          wght_rd_en_o   = 1'b1;
          wght_rd_addr_o = wght_cnt;
        end
        S_LD_ROWS: begin
          row_rd_en_o = 1'b1;
          if (out_row == '0)
            row_rd_addr_o = {2'b00, prime_cnt};
          else if (row_sum > {1'b0, IMG_LAST})
            row_rd_addr_o = IMG_LAST;
          else
            row_rd_addr_o = row_sum[4:0];
        end
        S_COMPUTE: begin
          mac_vld_o = 1'b1;
          col_sel_o = col_cnt;
        end
        S_DONE: begin
          frame_done_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
